// File: rtl/clk_div_prog.sv
// clk_div_prog: free-running clkdiv counter plus a glitch-free, power-of-two programmable Clk_CPU.
// Define CLK_DIV_STEP_EN to compile in single-step (step edge detector and STEP state).
module clk_div_prog #(
  parameter int CNT_W       = 32,
  parameter int SEL_W       = 5,
  parameter int DEFAULT_SEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  input  logic             pause,
  input  logic             step,
  output logic [CNT_W-1:0] clkdiv,
  output logic             Clk_CPU,
  output logic             cpu_en,
  output logic [SEL_W-1:0] sel_cur,
  output logic             paused
);

  localparam int MAX_SEL = CNT_W - 1;
  localparam logic [SEL_W-1:0] RESET_SEL =
    (DEFAULT_SEL > MAX_SEL) ? SEL_W'(MAX_SEL) : SEL_W'(DEFAULT_SEL);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PAUSED
`ifdef CLK_DIV_STEP_EN
    , ST_STEP
`endif
  } state_t;

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    if (int'(s) > MAX_SEL) clamp_sel = SEL_W'(MAX_SEL);
    else                   clamp_sel = s;
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] ph, ph_n, half_m1;
  logic             clk_cpu_n, rise;
  logic [SEL_W-1:0] sel_q, sel_cur_n;
  logic             step_edge;
  logic             at_end;

  assign half_m1 = (CNT_W'(1) << sel_cur) - CNT_W'(1);
  assign at_end  = (ph == half_m1);
  assign paused  = (state == ST_PAUSED);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    ph_n      = ph + CNT_W'(1);
    clk_cpu_n = Clk_CPU;
    sel_cur_n = sel_cur;
    rise      = 1'b0;
    case (state)
      ST_RUN: begin
        if (at_end) begin
          ph_n      = '0;
          clk_cpu_n = ~Clk_CPU;
          if (Clk_CPU) begin
            // Ratio and pause changes only land on a falling toggle.
            sel_cur_n = sel_q;
            if (pause) state_n = ST_PAUSED;
          end else begin
            rise = 1'b1;
          end
        end
      end
      ST_PAUSED: begin
        ph_n      = '0;
        clk_cpu_n = 1'b0;
        sel_cur_n = sel_q;
        if (!pause) begin
          state_n = ST_RUN;
        end
`ifdef CLK_DIV_STEP_EN
        else if (step_edge) begin
          state_n   = ST_STEP;
          clk_cpu_n = 1'b1;
          rise      = 1'b1;
        end
`endif
      end
`ifdef CLK_DIV_STEP_EN
      ST_STEP: begin
        if (at_end) begin
          ph_n      = '0;
          clk_cpu_n = 1'b0;
          sel_cur_n = sel_q;
          state_n   = pause ? ST_PAUSED : ST_RUN;
        end
      end
`endif
      default: begin
        state_n   = ST_RUN;
        ph_n      = '0;
        clk_cpu_n = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      ph      <= '0;
      Clk_CPU <= 1'b0;
      cpu_en  <= 1'b0;
      sel_cur <= RESET_SEL;
      sel_q   <= RESET_SEL;
    end else begin
      state   <= state_n;
      ph      <= ph_n;
      Clk_CPU <= clk_cpu_n;
      cpu_en  <= rise;
      sel_cur <= sel_cur_n;
      sel_q   <= clamp_sel(sel);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clkdiv <= '0;
    else     clkdiv <= clkdiv + CNT_W'(1);
  end

`ifdef CLK_DIV_STEP_EN
  logic step_q;

  // Edge is itself registered, so Clk_CPU rises two edges after step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q    <= 1'b0;
      step_edge <= 1'b0;
    end else begin
      step_q    <= step;
      step_edge <= step & ~step_q;
    end
  end
`else
  logic unused_step;
  assign unused_step = step;
  assign step_edge   = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: table-driven vectors plus hand sequences for ratio change, pause, step,
// asynchronous reset and clkdiv wrap (small second instance).
module tb_clk_div_prog;

`ifdef CLK_DIV_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  sel = '0;
  logic        pause = 1'b0;
  logic        step = 1'b0;
  logic [31:0] clkdiv;
  logic        clk_cpu, cpu_en, paused;
  logic [4:0]  sel_cur;

  logic [2:0]  sel_s = 3'd3;
  logic        pause_s = 1'b0;
  logic        step_s = 1'b0;
  logic [4:0]  clkdiv_s;
  logic        clk_cpu_s, cpu_en_s, paused_s;
  logic [2:0]  sel_cur_s;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clk_div_prog u_dut (
    .clk(clk), .rst(rst), .sel(sel), .pause(pause), .step(step),
    .clkdiv(clkdiv), .Clk_CPU(clk_cpu), .cpu_en(cpu_en), .sel_cur(sel_cur), .paused(paused)
  );

  clk_div_prog #(.CNT_W(5), .SEL_W(3), .DEFAULT_SEL(3)) u_small (
    .clk(clk), .rst(rst), .sel(sel_s), .pause(pause_s), .step(step_s),
    .clkdiv(clkdiv_s), .Clk_CPU(clk_cpu_s), .cpu_en(cpu_en_s), .sel_cur(sel_cur_s), .paused(paused_s)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  sel;
    logic        e_clk;
    logic        e_en;
    logic        e_paused;
    logic [4:0]  e_sel_cur;
    logic [31:0] e_clkdiv;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [4:0] s, input logic c, input logic e,
                              input logic p, input logic [4:0] sc, input logic [31:0] cd);
    vec_t v;
    v.rst = r; v.sel = s; v.e_clk = c; v.e_en = e; v.e_paused = p; v.e_sel_cur = sc; v.e_clkdiv = cd;
    return v;
  endfunction

  initial begin
    bit found;
    int hi, bad;

    // Reset, sel=0 toggles every edge; then sel=2; then sel=0 requested mid-high.
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 1, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 2);
    vecs[3]  = mk(0, 0, 1, 1, 0, 0, 3);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 4);
    vecs[5]  = mk(0, 2, 1, 1, 0, 0, 5);
    vecs[6]  = mk(0, 2, 0, 0, 0, 2, 6);
    vecs[7]  = mk(0, 2, 0, 0, 0, 2, 7);
    vecs[8]  = mk(0, 2, 0, 0, 0, 2, 8);
    vecs[9]  = mk(0, 2, 0, 0, 0, 2, 9);
    vecs[10] = mk(0, 2, 1, 1, 0, 2, 10);
    vecs[11] = mk(0, 0, 1, 0, 0, 2, 11);
    vecs[12] = mk(0, 0, 1, 0, 0, 2, 12);
    vecs[13] = mk(0, 0, 1, 0, 0, 2, 13);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 14);
    vecs[15] = mk(0, 0, 1, 1, 0, 0, 15);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 16);

    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst;
      sel = vecs[i].sel;
      tick();
      check($sformatf("vec%0d_clk", i), clk_cpu, vecs[i].e_clk);
      check($sformatf("vec%0d_en", i), cpu_en, vecs[i].e_en);
      check($sformatf("vec%0d_paused", i), paused, vecs[i].e_paused);
      check($sformatf("vec%0d_sel_cur", i), sel_cur, vecs[i].e_sel_cur);
      check($sformatf("vec%0d_clkdiv", i), clkdiv, vecs[i].e_clkdiv);
    end

    // Pause requested mid-high at sel=1.
    sel = 5'd1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (sel_cur == 5'd1 && clk_cpu) found = 1;
    end
    check("sel1_high_timeout", found, 1);
    pause = 1'b1;
    hi = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (clk_cpu) hi++;
      else found = 1;
    end
    check("pause_high_len", hi, 2);
    check("pause_paused_at_fall", paused, 1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (clk_cpu !== 1'b0 || paused !== 1'b1 || cpu_en !== 1'b0) bad++;
    end
    check("pause_hold_50", bad, 0);
    pause = 1'b0;
    tick();
    check("resume_paused_drop", paused, 0);
    check("resume_low0", clk_cpu, 0);
    tick();
    check("resume_low1", clk_cpu, 0);
    tick();
    check("resume_rise", clk_cpu, 1);
    check("resume_en", cpu_en, 1);
    tick();
    check("resume_en_single", cpu_en, 0);

    // Pause at sel=2 (sel change and pause on the same fall), then step three times.
    sel = 5'd2;
    pause = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (paused) found = 1;
    end
    check("pause2_timeout", found, 1);
    tick();
    check("paused_sel_applied", sel_cur, 2);
    for (int k = 0; k < 3; k++) begin
      int first_hi, n_hi, n_en;
      first_hi = 0; n_hi = 0; n_en = 0;
      step = 1'b1;
      for (int t = 1; t <= 20; t++) begin
        tick();
        if (t == 3) step = 1'b0;
        if (clk_cpu) begin
          n_hi++;
          if (first_hi == 0) first_hi = t;
        end
        if (cpu_en) n_en++;
      end
      check($sformatf("step%0d_first_hi", k), first_hi, STEP_EN ? 2 : 0);
      check($sformatf("step%0d_high_len", k), n_hi, STEP_EN ? 4 : 0);
      check($sformatf("step%0d_en_pulses", k), n_en, STEP_EN ? 1 : 0);
      check($sformatf("step%0d_paused_after", k), paused, 1);
    end

    // Asynchronous reset mid-high, then clkdiv wrap on the 5-bit instance.
    pause = 1'b0;
    sel = 5'd0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (clk_cpu) found = 1;
    end
    check("pre_reset_high_timeout", found, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_clk", clk_cpu, 0);
    check("async_rst_en", cpu_en, 0);
    check("async_rst_clkdiv", clkdiv, 0);
    check("async_rst_sel_cur", sel_cur, 0);
    check("async_rst_small_clkdiv", clkdiv_s, 0);
    tick();
    check("rst_held_clkdiv", clkdiv, 0);
    rst = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      check($sformatf("small_clkdiv_e%0d", n), clkdiv_s, 64'(n % 32));
      check($sformatf("small_clk_e%0d", n), clk_cpu_s, 64'((n >> 3) & 1));
      check($sformatf("small_en_e%0d", n), cpu_en_s, 64'(n % 16 == 8));
    end

    // Out-of-range select clamps to CNT_W-1.
    sel_s = 3'd7;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (sel_cur_s != 3'd3) found = 1;
    end
    check("clamp_timeout", found, 1);
    check("clamp_sel_cur", sel_cur_s, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable, glitch-free CPU clock generator for the board top level. A free-running `clkdiv` counter feeds the display and scan logic. A separately phased `Clk_CPU` output runs at a runtime-selectable power-of-two division of `clk`. Divide-ratio changes, pause and single-step all take effect only at `Clk_CPU` falling boundaries, so the CPU never sees a runt pulse.

## Interface
Parameters:
- `CNT_W`, 32, width of `clkdiv` and of the internal phase counter.
- `SEL_W`, 5, width of the divide-select input.
- `DEFAULT_SEL`, 0, divide select loaded at reset (clamped like `sel`).

Ports:
- `clk`  in  1  board clock; all state is updated on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sel`  in  SEL_W  requested divide exponent s; `Clk_CPU` period = 2^(s+1) `clk` cycles. Values above CNT_W-1 clamp to CNT_W-1.
- `pause`  in  1  level; request to freeze `Clk_CPU` low.
- `step`  in  1  level; each rising edge while paused yields one `Clk_CPU` period (requires `CLK_DIV_STEP_EN`).
- `clkdiv`  out  CNT_W  free-running counter.
- `Clk_CPU`  out  1  registered CPU clock, 50% duty.
- `cpu_en`  out  1  one-`clk` pulse, high in exactly the cycles in which `Clk_CPU` has just gone 0→1.
- `sel_cur`  out  SEL_W  divide exponent currently in effect.
- `paused`  out  1  high while in PAUSED.

## Operation
- `clkdiv`: +1 every `clk`; wraps from all-ones to 0; unaffected by `sel`, `pause` or `step`.
- Half-period h = 2^`sel_cur`. Phase counter `ph` (CNT_W bits):
  - When `ph` == h-1: `ph` ← 0 and `Clk_CPU` toggles.
  - Otherwise: `ph` ← `ph`+1.
- `sel` is sampled every cycle and clamped. If it differs from `sel_cur`, the new value is loaded only on a falling toggle (1→0), together with `ph` ← 0. The following low phase therefore uses the new h. No high or low phase is ever shorter than the smaller of the old and new h.
- State machine:
  - RUN: normal toggling. On a falling toggle with `pause`=1 → PAUSED.
  - PAUSED: `Clk_CPU`=0, `ph` held at 0; pending `sel` changes are applied immediately.
    - `pause`=0 → RUN. The first rising toggle comes h cycles later (full low phase).
    - Step edge (macro on) → STEP.
  - STEP: `Clk_CPU`=1 for h cycles, then falls. On the fall, → PAUSED if `pause`=1, else → RUN. Further step edges during STEP are ignored.
- Step edge detect: `step` is registered once; an edge is `step`=1 with the registered value = 0.
- `pause` rising mid-high-phase has no effect until the next fall. `pause` falling mid-phase in RUN is a no-op.
- If a `sel` change and a pause request coincide on the same fall, both apply: `sel_cur` updates and the state becomes PAUSED.

## Timing
- Reset values:
  - `clkdiv`=0, `ph`=0, `Clk_CPU`=0, `cpu_en`=0, `paused`=0.
  - `sel_cur`=clamped `DEFAULT_SEL`; state RUN; step edge register 0.
- After reset release, the first `Clk_CPU` rise occurs at rising edge number h, counting the first post-reset edge as 1. For s=0, `Clk_CPU` toggles on every edge, giving period 2 and the same waveform as `clkdiv[0]`.
- `cpu_en` is registered and coincides with the first high cycle of `Clk_CPU`.
- `sel` to `sel_cur` latency: at most one full `Clk_CPU` period plus 1 cycle (sample register).
- `pause` to `paused`: `paused` rises on the next falling toggle.
- Step edge in PAUSED:
  - `Clk_CPU` rises 2 cycles after `step` rises (edge register, then state).
  - `paused` drops in the same cycle and rises again on the fall.
- Asynchronous reset mid-phase forces all outputs to their reset values immediately. No partial pulse is completed.

## Configuration
- `CLK_DIV_STEP_EN` defined: step edge detector and the STEP state are compiled in.
- Not defined:
  - `step` is ignored and STEP is absent.
  - PAUSED exits only via `pause`=0.
  - All other behaviour is identical.

## Test plan
- Reset, `sel`=0: `Clk_CPU` toggles every edge; `cpu_en` high on every second cycle; `clkdiv` counts 0,1,2,…
- `sel`=3 from reset: first rise at edge 8; thereafter high for 8 cycles, low for 8; `clkdiv` reaches 16 after 16 edges.
- Running at `sel`=2, change `sel` to 0 mid-high-phase: the high phase completes its 4 cycles; `sel_cur`=0 at the fall; the next phases are 1 cycle long. Assert no phase is <1 or truncated.
- Assert `pause` mid-high at `sel`=1: the high phase completes 2 cycles, then `paused`=1 and `Clk_CPU` is held 0 for 50 cycles. Drop `pause`: the rise comes 2 cycles later, with `cpu_en` pulsing once.
- Macro on, paused at `sel`=2, pulse `step` three times, 20 cycles apart: exactly three 4-cycle highs, each starting 2 cycles after its `step` edge, with three `cpu_en` pulses. Macro off: zero pulses.
- Assert `rst` during a high phase and force `clkdiv` to wrap from all-ones: `Clk_CPU`, `cpu_en` and `clkdiv` go to 0 asynchronously; after the wrap, `clkdiv` reads 0 and `Clk_CPU` is undisturbed.
